ibex_mtimer: RTL and testbench



---
 rtl/ibex_mtimer.sv | 116 +++++++++++
 tb/tb_ibex_mtimer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) behind an Avalon-MM slave.
// Prescaled 64-bit time counter; the registered compare drives irq_timer_i.
module ibex_mtimer #(
  parameter int unsigned PRESCALE = 54,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  timer_avalon_s_address,
  input  logic        timer_avalon_s_read,
  input  logic        timer_avalon_s_write,
  input  logic [3:0]  timer_avalon_s_byteenable,
  input  logic [31:0] timer_avalon_s_writedata,
  output logic [31:0] timer_avalon_s_readdata,
  output logic        timer_avalon_s_readdatavalid,
  output logic        timer_avalon_s_waitrequest,
  output logic        irq_timer_o
);

  localparam logic [CNT_W-1:0] PS_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] ps_q;
  logic [63:0]      mtime_q, mtime_d;
  logic [63:0]      mtimecmp_q, mtimecmp_d;
  logic [31:0]      hi_shadow_q;
  logic             en_q;
  logic             tick;
  logic             wr_mlo, wr_mhi, wr_clo, wr_chi, wr_ctrl;
  logic             rd_fire;
  logic [31:0]      rd_mux;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  assign timer_avalon_s_waitrequest = 1'b0;

  assign wr_mlo  = timer_avalon_s_write && (timer_avalon_s_address == 3'd0);
  assign wr_mhi  = timer_avalon_s_write && (timer_avalon_s_address == 3'd1);
  assign wr_clo  = timer_avalon_s_write && (timer_avalon_s_address == 3'd2);
  assign wr_chi  = timer_avalon_s_write && (timer_avalon_s_address == 3'd3);
  assign wr_ctrl = timer_avalon_s_write && (timer_avalon_s_address == 3'd4);
  // A simultaneous write swallows the read: no response is generated.
  assign rd_fire = timer_avalon_s_read && !timer_avalon_s_write;

  assign tick = en_q && (ps_q == PS_MAX);

  always_comb begin
    mtime_d = mtime_q;
    // Software writes to mtime take priority and drop that cycle's increment.
    if (wr_mlo || wr_mhi) begin
      if (wr_mlo) mtime_d[31:0]  = merge(mtime_q[31:0],  timer_avalon_s_writedata,
                                         timer_avalon_s_byteenable);
      if (wr_mhi) mtime_d[63:32] = merge(mtime_q[63:32], timer_avalon_s_writedata,
                                         timer_avalon_s_byteenable);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  always_comb begin
    mtimecmp_d = mtimecmp_q;
    if (wr_clo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0],  timer_avalon_s_writedata,
                                          timer_avalon_s_byteenable);
    if (wr_chi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], timer_avalon_s_writedata,
                                          timer_avalon_s_byteenable);
  end

  always_comb begin
    rd_mux = 32'd0;
    unique case (timer_avalon_s_address)
      3'd0:    rd_mux = mtime_q[31:0];
      3'd1:    rd_mux = hi_shadow_q;
      3'd2:    rd_mux = mtimecmp_q[31:0];
      3'd3:    rd_mux = mtimecmp_q[63:32];
      3'd4:    rd_mux = {31'd0, en_q};
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ps_q       <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b1;
    end else begin
      if (!en_q || tick) ps_q <= '0;
      else               ps_q <= ps_q + 1'b1;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      if (wr_ctrl && timer_avalon_s_byteenable[0]) en_q <= timer_avalon_s_writedata[0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_shadow_q                  <= '0;
      timer_avalon_s_readdata      <= '0;
      timer_avalon_s_readdatavalid <= 1'b0;
      irq_timer_o                  <= 1'b0;
    end else begin
      timer_avalon_s_readdatavalid <= rd_fire;
      if (rd_fire) timer_avalon_s_readdata <= rd_mux;
      // Latch the upper half when the lower half is read so a LO/HI pair is coherent.
      if (rd_fire && timer_avalon_s_address == 3'd0) hi_shadow_q <= mtime_q[63:32];
      irq_timer_o <= (mtime_q >= mtimecmp_q);
    end
  end

endmodule

// File: tb/tb_ibex_mtimer.sv
// Directed bench for ibex_mtimer with PRESCALE=4.
// Inputs change on negedge; outputs are sampled on the following negedge.
module tb_ibex_mtimer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [3:0]  byteenable = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        waitrequest;
  logic        irq;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_i = ~clk_i;

  ibex_mtimer #(.PRESCALE(4), .CNT_W(16)) dut (
    .clk_i                        (clk_i),
    .rst_ni                       (rst_ni),
    .timer_avalon_s_address       (address),
    .timer_avalon_s_read          (read),
    .timer_avalon_s_write         (write),
    .timer_avalon_s_byteenable    (byteenable),
    .timer_avalon_s_writedata     (writedata),
    .timer_avalon_s_readdata      (readdata),
    .timer_avalon_s_readdatavalid (readdatavalid),
    .timer_avalon_s_waitrequest   (waitrequest),
    .irq_timer_o                  (irq)
  );

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address = a; writedata = d; byteenable = be; write = 1'b1;
    @(negedge clk_i);
    write = 1'b0; byteenable = '0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d, output logic v);
    address = a; read = 1'b1;
    @(negedge clk_i);
    read = 1'b0;
    d = readdata; v = readdatavalid;
  endtask

  task automatic test_reset();
    do_reset();
    nvec++;
    if (readdata !== 32'd0 || readdatavalid !== 1'b0 || irq !== 1'b0 || waitrequest !== 1'b0) begin
      nerr++;
      $display("FAIL reset_outputs: rdata=%h rvalid=%b irq=%b wait=%b, want 0/0/0/0",
               readdata, readdatavalid, irq, waitrequest);
    end
  endtask

  task automatic test_idle_count();
    logic [31:0] d; logic v; logic irq_seen;
    irq_seen = 1'b0;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_i);
      if (irq !== 1'b0) irq_seen = 1'b1;
    end
    nvec++;
    if (irq_seen) begin nerr++; $display("FAIL idle_irq: irq went %b, want 0", irq_seen); end
    rd(3'd0, d, v);
    nvec++;
    if (v !== 1'b1 || d !== 32'd10) begin
      nerr++; $display("FAIL idle_mtime_lo: got %h valid=%b, want 0000000a valid=1", d, v);
    end
    @(negedge clk_i);
    nvec++;
    if (readdatavalid !== 1'b0) begin
      nerr++; $display("FAIL rvalid_single: got %b, want 0", readdatavalid);
    end
  endtask

  task automatic test_irq();
    logic irq40, irq41;
    irq40 = 1'bx; irq41 = 1'bx;
    do_reset();
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'd10, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd2, 32'd20, 4'hF);
    wr(3'd3, 32'd0, 4'hF);
    wr(3'd4, 32'd1, 4'hF);
    // mtime hits 20 on the 40th edge after enable; irq follows one edge later
    for (int k = 1; k <= 41; k++) begin
      @(negedge clk_i);
      if (k == 40) irq40 = irq;
      if (k == 41) irq41 = irq;
    end
    nvec++;
    if (irq40 !== 1'b0) begin nerr++; $display("FAIL irq_before_match: got %b, want 0", irq40); end
    nvec++;
    if (irq41 !== 1'b1) begin nerr++; $display("FAIL irq_at_match: got %b, want 1", irq41); end
    wr(3'd2, 32'hFFFF_FFFF, 4'hF);
    nvec++;
    if (irq !== 1'b1) begin nerr++; $display("FAIL irq_fall_lag: got %b, want 1", irq); end
    @(negedge clk_i);
    nvec++;
    if (irq !== 1'b0) begin nerr++; $display("FAIL irq_fall: got %b, want 0", irq); end
  endtask

  task automatic test_wrap();
    logic [31:0] d; logic v; logic irq8, irq9;
    irq8 = 1'bx; irq9 = 1'bx;
    do_reset();
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd3, 32'd1, 4'hF);
    wr(3'd2, 32'd0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFE, 4'hF);
    wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd4, 32'd1, 4'hF);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk_i);
      if (k == 8) irq8 = irq;
      if (k == 9) irq9 = irq;
    end
    nvec++;
    if (irq8 !== 1'b1 || irq9 !== 1'b0) begin
      nerr++; $display("FAIL wrap_irq: got %b then %b, want 1 then 0", irq8, irq9);
    end
    rd(3'd0, d, v);
    nvec++;
    if (v !== 1'b1 || d !== 32'd0) begin
      nerr++; $display("FAIL wrap_lo: got %h valid=%b, want 00000000", d, v);
    end
    rd(3'd1, d, v);
    nvec++;
    if (v !== 1'b1 || d !== 32'd0) begin
      nerr++; $display("FAIL wrap_hi: got %h valid=%b, want 00000000", d, v);
    end
  endtask

  task automatic test_shadow();
    logic [31:0] d; logic v;
    do_reset();
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF);
    rd(3'd0, d, v);
    nvec++;
    if (v !== 1'b1 || d !== 32'hFFFF_FFFF) begin
      nerr++; $display("FAIL shadow_lo: got %h, want ffffffff", d);
    end
    wr(3'd4, 32'd1, 4'hF);
    repeat (4) @(negedge clk_i);
    wr(3'd4, 32'd0, 4'hF);
    rd(3'd1, d, v);
    nvec++;
    if (v !== 1'b1 || d !== 32'd0) begin
      nerr++; $display("FAIL shadow_hi: got %h, want 00000000 (shadowed)", d);
    end
    rd(3'd0, d, v);
    rd(3'd1, d, v);
    nvec++;
    if (d !== 32'd1) begin nerr++; $display("FAIL shadow_refresh: got %h, want 00000001", d); end
  endtask

  task automatic test_byteenable();
    logic [31:0] d; logic v;
    do_reset();
    wr(3'd2, 32'h0000_AB00, 4'b0010);
    rd(3'd2, d, v);
    nvec++;
    if (v !== 1'b1 || d !== 32'hFFFF_ABFF) begin
      nerr++; $display("FAIL be_cmp_lo: got %h, want ffffabff", d);
    end
    // read+write together: write lands, no response
    address = 3'd3; writedata = 32'h1234_5678; byteenable = 4'hF; write = 1'b1; read = 1'b1;
    @(negedge clk_i);
    write = 1'b0; read = 1'b0; byteenable = '0;
    nvec++;
    if (readdatavalid !== 1'b0) begin
      nerr++; $display("FAIL rw_collide_valid: got %b, want 0", readdatavalid);
    end
    rd(3'd3, d, v);
    nvec++;
    if (d !== 32'h1234_5678) begin nerr++; $display("FAIL rw_collide_write: got %h, want 12345678", d); end
    wr(3'd4, 32'hFFFF_FFF0, 4'hF);
    rd(3'd4, d, v);
    nvec++;
    if (d !== 32'd0) begin nerr++; $display("FAIL ctrl_mask: got %h, want 00000000", d); end
  endtask

  task automatic test_enable_and_reset();
    logic [31:0] d; logic v; logic [31:0] r4, r5; logic vall;
    logic [31:0] exp_regs [6];
    do_reset();
    wr(3'd4, 32'd0, 4'hF);
    wr(3'd0, 32'h0000_1234, 4'hF);
    repeat (100) @(negedge clk_i);
    rd(3'd0, d, v);
    nvec++;
    if (d !== 32'h0000_1234) begin nerr++; $display("FAIL frozen: got %h, want 00001234", d); end
    wr(3'd4, 32'd1, 4'hF);
    // back-to-back reads straddling the first tick after re-enable
    address = 3'd0; read = 1'b1; vall = 1'b1; r4 = '0; r5 = '0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk_i);
      if (readdatavalid !== 1'b1) vall = 1'b0;
      if (k == 4) r4 = readdata;
      if (k == 5) r5 = readdata;
    end
    read = 1'b0;
    nvec++;
    if (!vall) begin nerr++; $display("FAIL b2b_valid: a response was missing, want 5 valid"); end
    nvec++;
    if (r4 !== 32'h1234 || r5 !== 32'h1235) begin
      nerr++; $display("FAIL reenable_tick: got %h,%h, want 00001234,00001235", r4, r5);
    end
    // reset asserted while a read response is pending
    address = 3'd2; read = 1'b1;
    @(posedge clk_i);
    #1 rst_ni = 1'b0; read = 1'b0;
    #1;
    nvec++;
    if (readdatavalid !== 1'b0) begin nerr++; $display("FAIL reset_kill_valid: got %b, want 0", readdatavalid); end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    nvec++;
    if (readdatavalid !== 1'b0) begin nerr++; $display("FAIL post_reset_valid: got %b, want 0", readdatavalid); end
    exp_regs = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0};
    for (int i = 0; i < 6; i++) begin
      rd(3'(i), d, v);
      nvec++;
      if (v !== 1'b1 || d !== exp_regs[i]) begin
        nerr++; $display("FAIL reset_reg%0d: got %h valid=%b, want %h", i, d, v, exp_regs[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_count();
    test_irq();
    test_wrap();
    test_shadow();
    test_byteenable();
    test_enable_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
